// File: rtl/cpu_pkg.sv
// Shared types, segment constants and the BCD add-3 step for the GPIO display driver.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    localparam int unsigned BCD_DIGITS  = 10;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned DISP_DIGITS = 8;

    // Double-dabble correction: every digit >= 5 gets +3, digits never carry into each other.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}, digits 0-F.
module seg7_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = 7'h7F;
        case (i_nibble)
            4'h0: o_seg_c = 7'h40;
            4'h1: o_seg_c = 7'h79;
            4'h2: o_seg_c = 7'h24;
            4'h3: o_seg_c = 7'h30;
            4'h4: o_seg_c = 7'h19;
            4'h5: o_seg_c = 7'h12;
            4'h6: o_seg_c = 7'h02;
            4'h7: o_seg_c = 7'h78;
            4'h8: o_seg_c = 7'h00;
            4'h9: o_seg_c = 7'h10;
            4'hA: o_seg_c = 7'h08;
            4'hB: o_seg_c = 7'h03;
            4'hC: o_seg_c = 7'h46;
            4'hD: o_seg_c = 7'h21;
            4'hE: o_seg_c = 7'h06;
            4'hF: o_seg_c = 7'h0E;
            default: o_seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/gpio_display_driver.sv
// Drives eight active-low 7-segment displays from the CPU GPIO word, in decimal
// (sequential double-dabble) or hex; the displays update atomically per conversion.
module gpio_display_driver
    import cpu_pkg::*;
#(
    parameter bit          BLANK_LZ = 1'b1,
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] value,
    input  logic                hex_mode,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7,
    output logic                busy,
    output logic                overflow
);

    localparam int unsigned      CNT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);
    localparam logic [6:0]       SEG_RST_HI = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
    localparam logic [DISP_DIGITS-1:0][6:0] HEX_RST = {{(DISP_DIGITS-1){SEG_RST_HI}}, SEG_ZERO};

    logic [NUM_BITS-1:0]           r_value_q;
    logic                          r_mode_q;
    logic [NUM_BITS-1:0]           r_last_value;
    logic                          r_last_mode;
    disp_state_t                   r_state;
    disp_state_t                   w_state_nxt;
    logic [NUM_BITS-1:0]           r_bin;
    logic [BCD_W-1:0]              r_bcd;
    logic [CNT_W-1:0]              r_cnt;
    logic [DISP_DIGITS-1:0][6:0]   r_hex;
    logic                          r_busy;
    logic                          r_overflow;

    logic                          w_changed;
    logic                          w_latch;
    logic                          w_shift;
    logic                          w_update;
    logic [BCD_W-1:0]              w_bcd_adj;
    logic [DISP_DIGITS-1:0][3:0]   w_nib;
    logic [DISP_DIGITS-1:0][6:0]   w_seg;
    logic [DISP_DIGITS-1:0][6:0]   w_seg_nxt;
    logic [DISP_DIGITS-1:0]        w_lz;
    logic                          w_hi_zero;
    logic                          w_ovf_c;

    assign w_changed = (r_value_q != r_last_value) || (r_mode_q != r_last_mode);
    assign w_bcd_adj = bcd_adjust(r_bcd);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_shift     = 1'b0;
        w_update    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_changed) begin
                    w_latch     = 1'b1;
                    w_state_nxt = r_mode_q ? UPDATE : SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                w_update    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < DISP_DIGITS; g++) begin : g_dec
            assign w_nib[g] = r_last_mode ? r_bin[4*g +: 4] : r_bcd[4*g +: 4];
            seg7_decode u_dec (
                .i_nibble (w_nib[g]),
                .o_seg_c  (w_seg[g])
            );
        end
    endgenerate

    // Leading-zero blanking, overflow dashes and final segment selection
    always_comb begin
        w_ovf_c   = ~r_last_mode & (|r_bcd[BCD_W-1:4*DISP_DIGITS]);
        w_lz      = '0;
        w_hi_zero = 1'b1;
        for (int unsigned k = DISP_DIGITS - 1; k >= 1; k--) begin
            w_hi_zero = w_hi_zero & (w_nib[k] == 4'd0);
            w_lz[k]   = w_hi_zero & BLANK_LZ & ~r_last_mode;
        end
        for (int unsigned k = 0; k < DISP_DIGITS; k++) begin
            w_seg_nxt[k] = w_ovf_c ? SEG_DASH : (w_lz[k] ? SEG_BLANK : w_seg[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value_q    <= '0;
            r_mode_q     <= 1'b0;
            r_last_value <= '0;
            r_last_mode  <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_hex        <= HEX_RST;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_value_q <= value;
            r_mode_q  <= hex_mode;
            if (w_latch) begin
                r_bin        <= r_value_q;
                r_last_value <= r_value_q;
                r_last_mode  <= r_mode_q;
                r_bcd        <= '0;
                r_cnt        <= '0;
                r_busy       <= 1'b1;
            end else if (w_shift) begin
                {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 1'b1;
            end else if (w_update) begin
                r_hex      <= w_seg_nxt;
                r_overflow <= w_ovf_c;
                r_busy     <= 1'b0;
            end
        end
    end

    assign HEX0     = r_hex[0];
    assign HEX1     = r_hex[1];
    assign HEX2     = r_hex[2];
    assign HEX3     = r_hex[3];
    assign HEX4     = r_hex[4];
    assign HEX5     = r_hex[5];
    assign HEX6     = r_hex[6];
    assign HEX7     = r_hex[7];
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_gpio_display_driver.sv
// Directed, table-driven bench for gpio_display_driver (BLANK_LZ=1, NUM_BITS=32).
module tb_gpio_display_driver;

    localparam logic [6:0] B = 7'h7F;
    localparam logic [6:0] Z = 7'h40;
    localparam logic [6:0] D = 7'h3F;
    localparam logic [55:0] DISP_RST = {{7{B}}, Z};
    localparam int unsigned NV = 11;

    typedef struct {
        logic [31:0] value;
        logic        mode;
        logic [55:0] disp;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic        hex_mode;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic        busy;
    logic        overflow;

    int n_vec;
    int n_bad;
    vec_t tbl [NV];

    gpio_display_driver #(.BLANK_LZ(1'b1), .NUM_BITS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .hex_mode (hex_mode),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .HEX6     (HEX6),
        .HEX7     (HEX7),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] disp();
        return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Takes E0 (the edge loading value_q), then follows the conversion to its UPDATE edge.
    task automatic observe(input string nm, input int lat, input logic [55:0] old_d,
                           input logic [55:0] new_d, input logic ovf);
        int busy_cnt;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        chk({nm, " idle@E0"}, 64'(busy), 64'(1'b0));
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            if (i < lat && busy === 1'b1) busy_cnt++;
            if (i == lat - 1) chk({nm, " hold"}, 64'(disp()), 64'(old_d));
        end
        chk({nm, " disp"}, 64'(disp()), 64'(new_d));
        chk({nm, " ovf"}, 64'(overflow), 64'(ovf));
        chk({nm, " busy_done"}, 64'(busy), 64'(1'b0));
        chk({nm, " busy_len"}, 64'(busy_cnt), 64'(lat - 1));
    endtask

    task automatic drive(input logic [31:0] v, input logic m);
        @(negedge clk);
        value    = v;
        hex_mode = m;
    endtask

    initial begin
        logic [55:0] prev;
        logic [55:0] five;
        logic [55:0] nn;
        logic [55:0] ft;
        logic [55:0] exp_d;
        int          busy_seen;
        n_vec = 0;
        n_bad = 0;

        tbl[0]  = '{32'd12345678, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
        tbl[1]  = '{32'd100000000, 1'b0, {8{D}}, 1'b1};
        tbl[2]  = '{32'd7, 1'b0, {{7{B}}, 7'h78}, 1'b0};
        tbl[3]  = '{32'hDEADBEEF, 1'b1, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
        tbl[4]  = '{32'd0, 1'b0, {{7{B}}, Z}, 1'b0};
        tbl[5]  = '{32'd99999999, 1'b0, {8{7'h10}}, 1'b0};
        tbl[6]  = '{32'hFFFFFFFF, 1'b0, {8{D}}, 1'b1};
        tbl[7]  = '{32'h0000000A, 1'b1, {{7{Z}}, 7'h08}, 1'b0};
        tbl[8]  = '{32'd10, 1'b0, {{6{B}}, 7'h79, Z}, 1'b0};
        tbl[9]  = '{32'd1000, 1'b0, {{4{B}}, 7'h79, {3{Z}}}, 1'b0};
        tbl[10] = '{32'd0, 1'b1, {8{Z}}, 1'b0};

        // Asynchronous reset asserted mid-cycle, checked before any clock edge
        rst_n    = 1'b1;
        value    = '0;
        hex_mode = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset disp", 64'(disp()), 64'(DISP_RST));
        chk("reset flags", 64'({busy, overflow}), 64'(2'b00));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        prev = DISP_RST;
        for (int i = 0; i < int'(NV); i++) begin
            drive(tbl[i].value, tbl[i].mode);
            observe($sformatf("vec%0d", i), tbl[i].mode ? 2 : 34, prev, tbl[i].disp, tbl[i].ovf);
            prev = tbl[i].disp;
        end

        // Re-driving the same value must not start a conversion
        drive(32'd0, 1'b1);
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_seen++;
        end
        chk("same busy", 64'(busy_seen), 64'(0));
        chk("same disp", 64'(disp()), 64'(prev));

        // Value changes mid-SHIFT: "5" shows first, then "99", nothing else in between
        five = {{7{B}}, 7'h12};
        nn   = {{6{B}}, 7'h10, 7'h10};
        drive(32'd5, 1'b0);
        @(posedge clk);
        for (int i = 1; i <= 68; i++) begin
            @(posedge clk);
            #1;
            exp_d = (i < 34) ? prev : ((i < 68) ? five : nn);
            chk($sformatf("mid e%0d", i), 64'(disp()), 64'(exp_d));
            if (i == 10) begin
                @(negedge clk);
                value = 32'd99;
            end
        end
        chk("mid busy", 64'(busy), 64'(1'b0));

        // Reset pulse during SHIFT with 42 held, then a full conversion after release
        ft = {{6{B}}, 7'h19, 7'h24};
        drive(32'd42, 1'b0);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid disp", 64'(disp()), 64'(DISP_RST));
        chk("rst mid flags", 64'({busy, overflow}), 64'(2'b00));
        @(posedge clk);
        #1;
        chk("rst held busy", 64'(busy), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        observe("rst42", 34, DISP_RST, ft, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_display_driver.md
Name: gpio_display_driver

Overview:
- Downstream consumer of the CPU's 32-bit GPIO_out register; drives the board's eight active-low 7-segment displays HEX7..HEX0.
- Decimal mode: a sequential double-dabble FSM converts the unsigned value to BCD, one bit per cycle.
- Hex mode: the value's nibbles are shown directly.
- All display outputs are registered; they update atomically when a conversion completes.

Parameters:
- BLANK_LZ, 1, when 1, leading zero digits are blanked in decimal mode; HEX0 is never blanked.
- NUM_BITS, 32, binary input width; it sets the SHIFT iteration count.

Ports:
- clk  input  1  system clock, shared with the CPU.
- rst_n  input  1  reset, asynchronous and active-low.
- value  input  32  unsigned value to display; connects to CPU GPIO_out.
- hex_mode  input  1  1 = hexadecimal display, 0 = decimal display.
- HEX0..HEX7  output  7 each  segments {g,f,e,d,c,b,a}, active-low; HEX0 is the least significant digit.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  high when the displayed decimal value is at least 100_000_000.

Behaviour:
- Reset (async, rst_n=0), independent of clk:
  - HEX0 = 7'h40 ("0").
  - HEX1..HEX7 = 7'h7F (blank) if BLANK_LZ=1, else 7'h40.
  - busy=0, overflow=0.
  - value_q=0, mode_q=0, last_value=0, last_mode=0; state=IDLE.
  - A reset mid-conversion aborts immediately. After release, value is re-sampled and conversion restarts if it differs from 0 or hex_mode=1.
- Input sampling: value_q<=value and mode_q<=hex_mode on every edge.
- States: IDLE, SHIFT, UPDATE.
- IDLE:
  - If value_q!=last_value or mode_q!=last_mode: latch bin<=value_q, last_value<=value_q, last_mode<=mode_q; clear the 40-bit BCD register and the iteration counter.
  - Go to UPDATE if mode_q=1, else to SHIFT.
  - busy=1 from the latching edge.
- SHIFT, one iteration per cycle:
  - Each of the 10 BCD digits >=5 gets +3, with no carry between digits.
  - Then {bcd,bin} is shifted left by 1.
  - After NUM_BITS iterations (counter 0..31), go to UPDATE.
- UPDATE:
  - Load HEX0..7 from the 8 low BCD digits (decimal) or from bin nibbles (hex).
  - Set overflow.
  - busy<=0; go to IDLE.
- Latency, counted from the edge at which value_q first holds the new value:
  - Decimal: HEX outputs change 34 edges later (1 latch + 32 shift + 1 update).
  - Hex: HEX outputs change 2 edges later.
- Overflow (decimal):
  - Condition: any of BCD digits 8..9 nonzero.
  - overflow=1 and every HEX = 7'h3F (dash).
  - Hex mode forces overflow=0.
- Leading-zero blanking (decimal, BLANK_LZ=1): digit k (k>=1) is blank if it and all higher digits are 0. Value 0 shows a single "0".
- value changes during SHIFT:
  - Ignored by the running conversion; the displays never show a mixed result.
  - On return to IDLE the mismatch is detected and a new conversion starts, so the final display always matches the last stable value.
- hex_mode change during SHIFT: handled the same way as a value change.
- Back-to-back identical values: no new conversion; busy stays 0.
- No carry or overflow out of the BCD register: 32-bit max 4_294_967_295 fits in 10 digits.

Decomposition:
- Shared package cpu_pkg:
  - disp_state_t enum {IDLE, SHIFT, UPDATE}.
  - Constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, BCD_DIGITS=10.
- Sub-module seg7_decode: combinational, 4-bit nibble to 7-bit active-low segments (0-F).
  - Instanced 8 times.
  - Blank/dash selection is done in the parent.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> HEX0=7'h40, HEX1..7=7'h7F, busy=0, overflow=0 before the next edge.
- Decimal: value=12345678, hex_mode=0 -> busy high for 33 cycles. At latency 34, HEX7..HEX0 show 1,2,3,4,5,6,7,8; HEX0=7'h00 ("8"); HEX7=7'h79 ("1"); overflow=0.
- Overflow: value=100_000_000 -> all HEX=7'h3F, overflow=1. Then value=7 -> HEX0=7'h78 ("7"), HEX1..7=7'h7F, overflow=0.
- Hex: hex_mode=1, value=32'hDEADBEEF -> after 2 edges, HEX7..HEX0 = 21,06,08,21,03,06,06,0E; busy high for exactly 1 cycle.
- Mid-conversion change: value=5, then value=99 ten cycles into SHIFT -> the display shows "5" after the first conversion, then "99" (HEX1=HEX0=7'h10). Never any other intermediate pattern.
- Reset mid-SHIFT: pulse rst_n low for 1 cycle during SHIFT with value=42 held -> outputs return to reset values; after release a full conversion runs; HEX1=7'h19 ("4"), HEX0=7'h24 ("2").
